// File: rtl/writeback_queue.sv
// Writeback queue: merges load- and ALU-path writebacks into an in-order register-file write stream.
// Define WB_FORWARD_EN to drive fwd1_data/fwd2_data from the queue; otherwise they are tied to zero.
module writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        mem_ready,
  output logic        alu_ready,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  input  logic [4:0]  query_reg1,
  input  logic [4:0]  query_reg2,
  output logic        pending1,
  output logic        pending2,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          pop;
  logic          mem_need;
  logic          mem_push;
  logic          alu_push;
  logic [PW-1:0] alu_slot;

  // The head always drains, so the slot it vacates this cycle counts as free.
  always_comb begin
    pop       = (count != '0);
    free      = CW'(DEPTH) - count + CW'(pop);
    mem_need  = mem_valid && (mem_rd != '0);
    mem_ready = !reset && (free >= CW'(1));
    alu_ready = !reset && (free >= (CW'(1) + CW'(mem_need)));
    mem_push  = mem_valid && mem_ready && (mem_rd != '0);
    alu_push  = alu_valid && alu_ready && (alu_rd != '0);
    alu_slot  = tail + PW'(mem_push);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(mem_push) + PW'(alu_push);
      count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_push) begin
      rd_q[tail]   <= mem_rd;
      data_q[tail] <= mem_data;
    end
    if (alu_push) begin
      rd_q[alu_slot]   <= alu_rd;
      data_q[alu_slot] <= alu_data;
    end
  end

  always_comb begin
    RegWrite      = pop;
    WriteRegister = pop ? rd_q[head] : '0;
    WriteData     = pop ? data_q[head] : '0;
  end

  // Scan oldest to youngest so the last match leaves the youngest value.
  always_comb begin
    logic [PW-1:0] slot;
    logic          live;
    pending1 = 1'b0;
    pending2 = 1'b0;
`ifdef WB_FORWARD_EN
    fwd1_data = '0;
    fwd2_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      live = (CW'(i) < count);
      if (live && (query_reg1 != '0) && (rd_q[slot] == query_reg1)) begin
        pending1 = 1'b1;
`ifdef WB_FORWARD_EN
        fwd1_data = data_q[slot];
`endif
      end
      if (live && (query_reg2 != '0) && (rd_q[slot] == query_reg2)) begin
        pending2 = 1'b1;
`ifdef WB_FORWARD_EN
        fwd2_data = data_q[slot];
`endif
      end
    end
  end

`ifndef WB_FORWARD_EN
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: queue-based reference model compared every negedge, plus directed literal checks.
module tb_writeback_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_ready;
  logic        alu_ready;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  query_reg1;
  logic [4:0]  query_reg2;
  logic        pending1;
  logic        pending2;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;

  int total = 0;
  int bad   = 0;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_ready    (mem_ready),
    .alu_ready    (alu_ready),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .query_reg1   (query_reg1),
    .query_reg2   (query_reg2),
    .pending1     (pending1),
    .pending2     (pending2),
    .fwd1_data    (fwd1_data),
    .fwd2_data    (fwd2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit exp_mem_ready();
    return !reset;
  endfunction

  function automatic bit exp_alu_ready();
    int unsigned n;
    int unsigned fr;
    int unsigned need;
    n    = q.size();
    fr   = DEPTH - n + ((n > 0) ? 1 : 0);
    need = 1 + ((mem_valid && mem_rd != 0) ? 1 : 0);
    return !reset && (fr >= need);
  endfunction

  task automatic look(input logic [4:0] r, output bit p, output logic [31:0] f);
    p = 1'b0;
    f = '0;
    if (r != 0) begin
      foreach (q[i]) begin
        if (q[i].rd == r) begin
          p = 1'b1;
          f = q[i].data;
        end
      end
    end
`ifndef WB_FORWARD_EN
    f = '0;
`endif
  endtask

  // Reference model: one pop per edge when non-empty, then accepted pushes in mem-then-alu order.
  always @(posedge clk or posedge reset) begin : model
    bit mv;
    bit av;
    if (reset) begin
      q.delete();
    end else begin
      mv = mem_valid && exp_mem_ready() && (mem_rd != 0);
      av = alu_valid && exp_alu_ready() && (alu_rd != 0);
      if (q.size() > 0) void'(q.pop_front());
      if (mv) q.push_back({mem_rd, mem_data});
      if (av) q.push_back({alu_rd, alu_data});
    end
  end

  always @(negedge clk) begin : compare
    bit          p1;
    bit          p2;
    logic [31:0] f1;
    logic [31:0] f2;
    look(query_reg1, p1, f1);
    look(query_reg2, p2, f2);
    chk("cmp_mem_ready", mem_ready, exp_mem_ready());
    chk("cmp_alu_ready", alu_ready, exp_alu_ready());
    chk("cmp_RegWrite", RegWrite, (q.size() > 0));
    chk("cmp_WriteRegister", WriteRegister, (q.size() > 0) ? q[0].rd : 5'd0);
    chk("cmp_WriteData", WriteData, (q.size() > 0) ? q[0].data : 32'd0);
    chk("cmp_pending1", pending1, p1);
    chk("cmp_pending2", pending2, p2);
    chk("cmp_fwd1", fwd1_data, f1);
    chk("cmp_fwd2", fwd2_data, f2);
  end

  function automatic logic [4:0] pick_rd();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic idle_inputs();
    mem_valid = 1'b0;
    mem_rd    = '0;
    mem_data  = '0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
  endtask

  initial begin
    bit hold_m;
    bit hold_a;
    reset = 1'b1;
    idle_inputs();
    query_reg1 = '0;
    query_reg2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_ready", mem_ready, 32'd0);
    chk("rst_alu_ready", alu_ready, 32'd0);
    chk("rst_RegWrite", RegWrite, 32'd0);
    #1 reset = 1'b0;

    // single load writeback
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("single_pre_RegWrite", RegWrite, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("single_RegWrite", RegWrite, 32'd1);
    chk("single_WriteRegister", WriteRegister, 32'd5);
    chk("single_WriteData", WriteData, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_after_RegWrite", RegWrite, 32'd0);

    // same-cycle mem+alu ordering
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    @(negedge clk);
    chk("pair_alu_ready", alu_ready, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("pair_first_rd", WriteRegister, 32'd3);
    chk("pair_first_data", WriteData, 32'h11);
    @(negedge clk);
    chk("pair_second_rd", WriteRegister, 32'd4);
    chk("pair_second_data", WriteData, 32'h22);
    @(negedge clk);
    chk("pair_done_RegWrite", RegWrite, 32'd0);

    // rd==0 is accepted and discarded
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    @(negedge clk);
    chk("r0_alu_ready", alu_ready, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r0_no_RegWrite", RegWrite, 32'd0);
    end

    // youngest-value forwarding / pending
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h2;
    query_reg1 = 5'd7; query_reg2 = 5'd0;
    @(negedge clk);
    chk("fwd_ignore_incoming", pending1, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("fwd_pending1", pending1, 32'd1);
    chk("fwd_pending2_r0", pending2, 32'd0);
`ifdef WB_FORWARD_EN
    chk("fwd_data1", fwd1_data, 32'h2);
`else
    chk("fwd_data1", fwd1_data, 32'h0);
`endif
    repeat (3) @(negedge clk);
    chk("fwd_drained_pending1", pending1, 32'd0);

    // fill to DEPTH and push at full across pointer wrap
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'hA1;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA2;
    @(posedge clk); #1;
    mem_rd = 5'd3; mem_data = 32'hA3; alu_rd = 5'd4; alu_data = 32'hA4;
    @(posedge clk); #1;
    mem_rd = 5'd5; mem_data = 32'hA5; alu_rd = 5'd6; alu_data = 32'hA6;
    @(posedge clk); #1;
    mem_rd = 5'd8; mem_data = 32'hA8; alu_rd = 5'd9; alu_data = 32'hA9;
    @(negedge clk);
    chk("full_mem_ready", mem_ready, 32'd1);
    chk("full_alu_ready", alu_ready, 32'd0);
    chk("full_head_rd", WriteRegister, 32'd3);
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_rd = '0;
    @(negedge clk);
    chk("full_held_alu_ready", alu_ready, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    repeat (DEPTH + 2) @(negedge clk);
    chk("full_drained", RegWrite, 32'd0);

    // randomized traffic; producers hold a request until it is accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hold_m = mem_valid && !mem_ready;
      hold_a = alu_valid && !alu_ready;
      @(posedge clk); #1;
      if (!hold_m) begin
        mem_valid = ($urandom_range(0, 9) < 6);
        mem_rd    = pick_rd();
        mem_data  = $urandom;
      end
      if (!hold_a) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_rd    = pick_rd();
        alu_data  = $urandom;
      end
      query_reg1 = pick_rd();
      query_reg2 = pick_rd();
    end
    @(negedge clk);
    @(posedge clk); #1;
    idle_inputs();
    repeat (DEPTH + 2) @(negedge clk);

    // asynchronous reset with three entries queued
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hB0;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB1;
    @(posedge clk); #1;
    mem_rd = 5'd12; mem_data = 32'hB2; alu_rd = 5'd13; alu_data = 32'hB3;
    @(posedge clk); #1;
    idle_inputs();
    query_reg1 = 5'd13; query_reg2 = 5'd0;
    @(negedge clk);
    chk("rst3_pending1_before", pending1, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst3_RegWrite", RegWrite, 32'd0);
    chk("rst3_WriteData", WriteData, 32'd0);
    chk("rst3_pending1", pending1, 32'd0);
    chk("rst3_fwd1", fwd1_data, 32'd0);
    chk("rst3_mem_ready", mem_ready, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst3_no_drain", RegWrite, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
